mmbf_chan_sched: RTL and testbench

Multichannel TDM input scheduler for the multistage half-band decimation chain. Up to 16 independent per-channel sample streams are buffered in small per-channel FIFOs and interleaved round-robin onto the chain's single sample/valid/channel-index input. Issues are spaced at least ISSUE_GAP cycles apart so that each filter stage's iterative MAC has time to finish. Issue is held off while the chain is being reconfigured.

---
 rtl/mmbf_sched_pkg.sv | 12 +
 rtl/mmbf_sched_fifo.sv | 51 +++++
 rtl/mmbf_chan_sched.sv | 142 ++++++++++++++
 tb/tb_mmbf_chan_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmbf_sched_pkg.sv
// Shared constants and state encoding for the half-band chain input scheduler.
package mmbf_sched_pkg;

  localparam int CHIDX_WIDTH      = 4;
  localparam int MBF_MAX_CHANNELS = 16;

  typedef enum logic {
    S_READY = 1'b0,
    S_GAP   = 1'b1
  } state_t;

endpackage

// File: rtl/mmbf_sched_fifo.sv
// Per-channel synchronous FIFO with show-ahead head output and synchronous flush.
module mmbf_sched_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  // The extra pointer MSB tells a full buffer apart from an empty one.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmbf_chan_sched.sv
// Round-robin TDM scheduler feeding per-channel samples into the decimation chain with a minimum issue gap.
module mmbf_chan_sched
  import mmbf_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NCH*DATA_WIDTH-1:0] Ch_Data_In,
  input  logic [NCH-1:0]            Ch_Valid,
  output logic [NCH-1:0]            Ch_Ready,
  input  logic [NCH-1:0]            Ch_Enable,
  input  logic                      Cfg_Busy,
  input  logic                      Flush,
  output logic [DATA_WIDTH-1:0]     Data_Out,
  output logic                      Data_Out_Valid,
  output logic [CHIDX_WIDTH-1:0]    Data_Out_ChIdx
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [CHIDX_WIDTH-1:0] LAST_CH = CHIDX_WIDTH'(NCH - 1);

  state_t                   state;
  state_t                   next_state;
  logic [GAP_W-1:0]         gap;
  logic [GAP_W-1:0]         gap_next;
  logic [CHIDX_WIDTH-1:0]   rr_ptr;
  logic [CHIDX_WIDTH-1:0]   grant_idx;
  logic [CHIDX_WIDTH-1:0]   cand;
  logic                     grant_found;
  logic                     issue;

  logic [NCH-1:0]              push;
  logic [NCH-1:0]              pop;
  logic [NCH-1:0]              empty;
  logic [NCH-1:0]              full;
  logic [MBF_MAX_CHANNELS-1:0] eligible;
  logic [DATA_WIDTH-1:0]       head [MBF_MAX_CHANNELS];

  // Channel slots beyond NCH are tied off so the arbiter can index a fixed 16-entry view.
  for (genvar k = 0; k < MBF_MAX_CHANNELS; k++) begin : g_ch
    if (k < NCH) begin : g_used
      assign push[k]     = Ch_Valid[k] && !full[k] && !Flush;
      assign pop[k]      = issue && (grant_idx == CHIDX_WIDTH'(k));
      assign eligible[k] = Ch_Enable[k] && !empty[k];
      assign Ch_Ready[k] = !full[k];

      mmbf_sched_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
      ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .flush (Flush),
        .push  (push[k]),
        .pop   (pop[k]),
        .din   (Ch_Data_In[k*DATA_WIDTH +: DATA_WIDTH]),
        .dout  (head[k]),
        .empty (empty[k]),
        .full  (full[k])
      );
    end else begin : g_unused
      assign eligible[k] = 1'b0;
      assign head[k]     = '0;
    end
  end

  // Search starts just past the last grant so every enabled channel gets a turn.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CHIDX_WIDTH'((int'(rr_ptr) + i) % NCH);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register (with gap counter)
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_READY;
      gap   <= '0;
    end else if (Flush) begin
      state <= S_READY;
      gap   <= '0;
    end else begin
      state <= next_state;
      gap   <= gap_next;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    gap_next   = gap;
    case (state)
      S_READY: begin
        if (issue && (ISSUE_GAP > 1)) begin
          next_state = S_GAP;
          gap_next   = GAP_W'(ISSUE_GAP - 1);
        end
      end
      S_GAP: begin
        gap_next = gap - GAP_W'(1);
        if (gap == GAP_W'(1)) next_state = S_READY;
      end
      default: next_state = S_READY;
    endcase
  end

  // Output decode
  always_comb begin
    issue = (state == S_READY) && !Cfg_Busy && grant_found && !Flush;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr         <= LAST_CH;
      Data_Out       <= '0;
      Data_Out_ChIdx <= '0;
      Data_Out_Valid <= 1'b0;
    end else begin
      Data_Out_Valid <= issue;
      if (Flush) begin
        rr_ptr <= LAST_CH;
      end else if (issue) begin
        rr_ptr         <= grant_idx;
        Data_Out       <= head[grant_idx];
        Data_Out_ChIdx <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_mmbf_chan_sched.sv
// Directed bench for mmbf_chan_sched: 4 channels, depth-4 FIFOs, issue gap of 4.
module tb_mmbf_chan_sched;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int FD  = 4;
  localparam int GAP = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NCH*DW-1:0] Ch_Data_In;
  logic [NCH-1:0]    Ch_Valid;
  logic [NCH-1:0]    Ch_Ready;
  logic [NCH-1:0]    Ch_Enable;
  logic              Cfg_Busy;
  logic              Flush;
  logic [DW-1:0]     Data_Out;
  logic              Data_Out_Valid;
  logic [3:0]        Data_Out_ChIdx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mmbf_chan_sched #(
    .DATA_WIDTH (DW),
    .NCH        (NCH),
    .FIFO_DEPTH (FD),
    .ISSUE_GAP  (GAP)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .Ch_Data_In     (Ch_Data_In),
    .Ch_Valid       (Ch_Valid),
    .Ch_Ready       (Ch_Ready),
    .Ch_Enable      (Ch_Enable),
    .Cfg_Busy       (Cfg_Busy),
    .Flush          (Flush),
    .Data_Out       (Data_Out),
    .Data_Out_Valid (Data_Out_Valid),
    .Data_Out_ChIdx (Data_Out_ChIdx)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    Ch_Data_In[ch*DW +: DW] = v;
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (Data_Out_Valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; Ch_Data_In = '0; Ch_Valid = '0; Ch_Enable = '0;
    Cfg_Busy = 1'b0; Flush = 1'b0;
    #23 nRST = 1'b1;
    step();
    checks++; if (Data_Out !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", Data_Out); end
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Data_Out_Valid); end
    checks++; if (Data_Out_ChIdx !== 4'h0) begin errors++; $display("FAIL reset_idx: got %h expected 0", Data_Out_ChIdx); end
    checks++; if (Ch_Ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b expected 1111", Ch_Ready); end
  endtask

  task automatic test_single_sample();
    Ch_Enable = '1;
    step();
    set_data(1, 24'h000123); Ch_Valid = 4'b0010;
    step();
    Ch_Valid = '0;
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", Data_Out_Valid); end
    step();
    checks++; if (Data_Out_Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", Data_Out_Valid); end
    checks++; if (Data_Out !== 24'h000123) begin errors++; $display("FAIL single_data: got %h expected 000123", Data_Out); end
    checks++; if (Data_Out_ChIdx !== 4'd1) begin errors++; $display("FAIL single_idx: got %0d expected 1", Data_Out_ChIdx); end
    step();
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", Data_Out_Valid); end
    checks++; if (Data_Out !== 24'h000123) begin errors++; $display("FAIL single_hold: got %h expected 000123", Data_Out); end
    idle(6);
  endtask

  task automatic test_round_robin();
    bit got;
    int last;
    Flush = 1'b1;
    step();
    Flush = 1'b0; Ch_Enable = '0;
    for (int n = 0; n < 3; n++) begin
      for (int ch = 0; ch < NCH; ch++) set_data(ch, 24'(ch * 256 + n));
      Ch_Valid = '1;
      step();
    end
    Ch_Valid = '0;
    checks++; if (Ch_Ready !== 4'hF) begin errors++; $display("FAIL rr_ready_preload: got %b expected 1111", Ch_Ready); end
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL rr_disabled_issue: got %b expected 0", Data_Out_Valid); end
    Ch_Enable = '1;
    last = 0;
    for (int k = 0; k < 12; k++) begin
      wait_pulse(10, got);
      checks++; if (!got) begin errors++; $display("FAIL rr_timeout[%0d]: got none expected pulse", k); end
      checks++; if (Data_Out_ChIdx !== 4'(k % 4)) begin errors++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", k, Data_Out_ChIdx, k % 4); end
      checks++; if (Data_Out !== 24'((k % 4) * 256 + k / 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, Data_Out, 24'((k % 4) * 256 + k / 4)); end
      if (k > 0) begin
        checks++; if (cyc - last !== GAP) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, cyc - last, GAP); end
      end
      last = cyc;
    end
    wait_pulse(10, got);
    checks++; if (got) begin errors++; $display("FAIL rr_extra: got pulse expected none"); end
  endtask

  task automatic test_full_fifo();
    bit got;
    Ch_Enable = '0;
    for (int i = 0; i < 5; i++) begin
      set_data(0, 24'(8'hA0 + i)); Ch_Valid = 4'b0001;
      checks++; if (Ch_Ready[0] !== (i < 4)) begin errors++; $display("FAIL full_ready_before[%0d]: got %b expected %b", i, Ch_Ready[0], i < 4); end
      step();
    end
    Ch_Valid = '0;
    checks++; if (Ch_Ready !== 4'b1110) begin errors++; $display("FAIL full_ready: got %b expected 1110", Ch_Ready); end
    Ch_Enable = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(10, got);
      checks++; if (!got) begin errors++; $display("FAIL full_timeout[%0d]: got none expected pulse", i); end
      checks++; if (Data_Out !== 24'(8'hA0 + i)) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, Data_Out, 24'(8'hA0 + i)); end
      checks++; if (Data_Out_ChIdx !== 4'd0) begin errors++; $display("FAIL full_idx[%0d]: got %0d expected 0", i, Data_Out_ChIdx); end
    end
    wait_pulse(12, got);
    checks++; if (got) begin errors++; $display("FAIL full_fifth_dropped: got pulse data %h expected none", Data_Out); end
    checks++; if (Ch_Ready !== 4'hF) begin errors++; $display("FAIL full_ready_after: got %b expected 1111", Ch_Ready); end
  endtask

  task automatic test_cfg_busy();
    int pulses;
    Ch_Enable = '1; Cfg_Busy = 1'b1;
    set_data(2, 24'h55AA33); Ch_Valid = 4'b0100;
    step();
    Ch_Valid = '0;
    pulses = Data_Out_Valid ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (Data_Out_Valid) pulses++;
    end
    Cfg_Busy = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL busy_hold: got %0d pulses expected 0", pulses); end
    step();
    checks++; if (Data_Out_Valid !== 1'b1) begin errors++; $display("FAIL busy_resume: got %b expected 1", Data_Out_Valid); end
    checks++; if (Data_Out !== 24'h55AA33) begin errors++; $display("FAIL busy_data: got %h expected 55aa33", Data_Out); end
    checks++; if (Data_Out_ChIdx !== 4'd2) begin errors++; $display("FAIL busy_idx: got %0d expected 2", Data_Out_ChIdx); end
    idle(6);
  endtask

  task automatic test_flush();
    bit got;
    Ch_Enable = '1;
    set_data(3, 24'h333333); Ch_Valid = 4'b1000;
    step();
    set_data(1, 24'h111111); Ch_Valid = 4'b0010; Flush = 1'b1;
    step();
    Flush = 1'b0; Ch_Valid = '0;
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_no_pulse: got %b expected 0", Data_Out_Valid); end
    wait_pulse(10, got);
    checks++; if (got) begin errors++; $display("FAIL flush_empty: got pulse data %h expected none", Data_Out); end
    set_data(0, 24'h0000C0); set_data(3, 24'h0000C3); Ch_Valid = 4'b1001;
    step();
    Ch_Valid = '0;
    wait_pulse(5, got);
    checks++; if (!got || Data_Out_ChIdx !== 4'd0) begin errors++; $display("FAIL flush_first_ch0: got valid %b idx %0d expected idx 0", got, Data_Out_ChIdx); end
    checks++; if (Data_Out !== 24'h0000C0) begin errors++; $display("FAIL flush_first_data: got %h expected 0000c0", Data_Out); end
    wait_pulse(8, got);
    checks++; if (!got || Data_Out_ChIdx !== 4'd3) begin errors++; $display("FAIL flush_second_ch3: got valid %b idx %0d expected idx 3", got, Data_Out_ChIdx); end
    checks++; if (Data_Out !== 24'h0000C3) begin errors++; $display("FAIL flush_second_data: got %h expected 0000c3", Data_Out); end
    idle(6);
  endtask

  task automatic test_async_reset();
    bit got;
    Ch_Enable = '1;
    set_data(1, 24'h0A0001); set_data(2, 24'h0A0002); Ch_Valid = 4'b0110;
    step();
    Ch_Valid = '0;
    wait_pulse(5, got);
    checks++; if (!got || Data_Out !== 24'h0A0001) begin errors++; $display("FAIL arst_pre: got valid %b data %h expected 0a0001", got, Data_Out); end
    step();
    #2 nRST = 1'b0;
    #1;
    checks++; if (Data_Out !== 24'h0) begin errors++; $display("FAIL arst_data: got %h expected 000000", Data_Out); end
    checks++; if (Data_Out_Valid !== 1'b0 || Data_Out_ChIdx !== 4'h0) begin errors++; $display("FAIL arst_ctrl: got valid %b idx %0d expected 0 0", Data_Out_Valid, Data_Out_ChIdx); end
    checks++; if (Ch_Ready !== 4'hF) begin errors++; $display("FAIL arst_ready: got %b expected 1111", Ch_Ready); end
    @(posedge CLK);
    #3 nRST = 1'b1;
    wait_pulse(8, got);
    checks++; if (got) begin errors++; $display("FAIL arst_lost: got pulse data %h expected none", Data_Out); end
    set_data(2, 24'h0B0002); set_data(0, 24'h0B0000); Ch_Valid = 4'b0101;
    step();
    Ch_Valid = '0;
    checks++; if (Data_Out_Valid !== 1'b0) begin errors++; $display("FAIL arst_early: got %b expected 0", Data_Out_Valid); end
    step();
    checks++; if (Data_Out_Valid !== 1'b1 || Data_Out_ChIdx !== 4'd0) begin errors++; $display("FAIL arst_first: got valid %b idx %0d expected 1 0", Data_Out_Valid, Data_Out_ChIdx); end
    checks++; if (Data_Out !== 24'h0B0000) begin errors++; $display("FAIL arst_first_data: got %h expected 0b0000", Data_Out); end
    wait_pulse(8, got);
    checks++; if (!got || Data_Out_ChIdx !== 4'd2 || Data_Out !== 24'h0B0002) begin errors++; $display("FAIL arst_second: got valid %b idx %0d data %h expected idx 2 data 0b0002", got, Data_Out_ChIdx, Data_Out); end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_round_robin();
    test_full_fifo();
    test_cfg_busy();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
